// File: rtl/hf_ssp_tx_if.sv
// Producer-side word handshake into the HF SSP serializer.
// Latency: n/a (wires only).
// Backpressure: producer holds in_data/in_valid until a cycle with in_ready high.
//
// Signals:
//   in_data  - word to send (WIDTH bits)
//   in_valid - producer offers in_data this cycle
//   in_ready - serializer accepts the offered word this cycle
interface hf_ssp_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/hf_ssp_tx.sv
// Framed SSP serializer: queues HF sample words and shifts each out MSB-first with ssp_clk/ssp_frame.
// Latency: word accepted at edge N into an empty FIFO with tx_en high drives its MSB from edge N+1.
// Backpressure: in_ready = registered (fifo_level < DEPTH); with HF_SSP_TX_DROP_EN, in_ready=1 and overflow is dropped/counted.
//
// Ports: ck_1356meg (clock), nreset (sync active-low reset), tx_en (allow new words),
//        in_if (slave word handshake), ssp_clk/ssp_frame/ssp_din (SSP link to ARM),
//        busy (word in flight), fifo_level (queued words), ovf_count (dropped words, drop build only).
// Optional feature macro: HF_SSP_TX_DROP_EN (never stall producer, drop and count overflow).
module hf_ssp_tx #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 4
) (
    input  logic                     ck_1356meg,
    input  logic                     nreset,
    input  logic                     tx_en,
    hf_ssp_tx_if.slave               in_if,
    output logic                     ssp_clk,
    output logic                     ssp_frame,
    output logic                     ssp_din,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
    localparam logic [BW-1:0] BIT_FIRST = BW'(WIDTH - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DW-1:0]     div_q, div_d;
    logic              push, pop, full, empty;

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

`ifdef HF_SSP_TX_DROP_EN
    logic [7:0] ovf_q, ovf_d;

    // Producer never stalls; a word offered while full is simply not written.
    assign in_if.in_ready = 1'b1;
    assign push           = in_if.in_valid & ~full;
    assign ovf_count      = ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (in_if.in_valid && full && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) ovf_q <= 8'd0;
        else         ovf_q <= ovf_d;
    end
`else
    logic in_ready_q;

    // Registered from next level so it always equals (fifo_level < DEPTH) outside reset.
    assign in_if.in_ready = in_ready_q;
    assign push           = in_if.in_valid & in_ready_q;
    assign ovf_count      = 8'd0;

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) in_ready_q <= 1'b0;
        else         in_ready_q <= (level_d < LVL_FULL);
    end
`endif

    // Shifter FSM: pop decisions happen in IDLE or on the last wrap of a word,
    // so consecutive words run without an idle bit.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == '0) begin
                        if (tx_en && !empty) pop = 1'b1;
                        else                 state_d = S_IDLE;
                    end else begin
                        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                        bit_d = bit_q - BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            sr_d  = mem_q[rd_ptr_q];
            bit_d = BIT_FIRST;
            div_d = '0;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge ck_1356meg) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            sr_q     <= '0;
            bit_q    <= '0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign ssp_clk    = busy & (div_q >= DIV_HALF);
    assign ssp_frame  = busy & (bit_q == BIT_FIRST);
    assign ssp_din    = busy & sr_q[WIDTH-1];
    assign fifo_level = level_q;
endmodule
